// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI byte sequencer: FSM state encoding and FIFO entry layout.
package spi_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        STORE     = 3'd4
    } state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Registered synchronous FIFO, valid/ready both sides; a write lands one cycle later at the head.
// Full accepts a write only alongside a read, so count holds and order is kept.
module spi_seq_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld && rd_rdy;
    assign wr_rdy  = !rst && ((count != FULL) || rd_fire);
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds host bytes to the SPI master one at a time and collects replies; spi_en 1 cycle after launch is possible.
// Host stalls on a full TX FIFO; no byte is launched unless the RX FIFO has a free slot.
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    output logic              spi_en,
    output logic [BYTE_W-1:0] spi_tx_data,
    input  logic              spi_busy,
    input  logic [BYTE_W-1:0] spi_rx_data,
    output logic              cs_n,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] RX_FULL  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    TO_LIMIT = 8'(BUSY_TIMEOUT);

    state_t      state;
    fifo_entry_t tx_in;
    fifo_entry_t tx_head;
    fifo_entry_t rx_in;
    fifo_entry_t rx_head;
    logic        tx_vld;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_wr_rdy;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic        last_q;
    logic        flush_q;
    logic [7:0]  busy_cnt;
    logic        timeout_hit;

    assign tx_in   = {s_last, s_data};
    assign rx_in   = {last_q, spi_rx_data};
    assign m_data  = rx_head.data;
    assign m_last  = rx_head.last;
    assign rx_push = (state == STORE);

    // TX head is latched on the way into LAUNCH and only retired there, or dropped while flushing a dead frame.
    assign tx_pop = (state == LAUNCH) || ((state == IDLE) && flush_q && (tx_count != '0));

    assign timeout_hit = (state == WAIT_BUSY) && !spi_busy && (busy_cnt == TO_LIMIT);

    spi_seq_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s_valid),
        .wr_rdy (s_ready),
        .wr_dat (tx_in),
        .rd_vld (tx_vld),
        .rd_rdy (tx_pop),
        .rd_dat (tx_head),
        .count  (tx_count)
    );

    spi_seq_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rx_push),
        .wr_rdy (rx_wr_rdy),
        .wr_dat (rx_in),
        .rd_vld (m_valid),
        .rd_rdy (m_ready),
        .rd_dat (rx_head),
        .count  (rx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            spi_en      <= 1'b0;
            spi_tx_data <= '0;
            cs_n        <= 1'b1;
            err_timeout <= 1'b0;
            last_q      <= 1'b0;
            flush_q     <= 1'b0;
            busy_cnt    <= '0;
        end else begin
            spi_en <= 1'b0;

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (flush_q) begin
                        if ((tx_count != '0) && tx_head.last) begin
                            flush_q <= 1'b0;
                        end
                    end else if (tx_vld && (rx_count != RX_FULL) && !spi_busy) begin
                        state       <= LAUNCH;
                        spi_en      <= 1'b1;
                        spi_tx_data <= tx_head.data;
                        last_q      <= tx_head.last;
                        cs_n        <= 1'b0;
                    end
                end
                LAUNCH: begin
                    busy_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= WAIT_DONE;
                    end else if (timeout_hit) begin
                        cs_n    <= 1'b1;
                        flush_q <= !last_q;
                        state   <= IDLE;
                    end else if (busy_cnt != 8'hFF) begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    if (rx_wr_rdy) begin
                        if (last_q) begin
                            cs_n <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
